// File: rtl/shft_cmd_ctrl_pkg.sv
// Shared types and constants for the shifter command issuer.
// FSM encoding, shifter direction values, default amount width.
package shft_cmd_ctrl_pkg;

  localparam int AMT_W_DEF = 7;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/shft_cmd_fifo.sv
// Circular command buffer with registered occupancy.
// Reads are from the head register; no fall-through.
module shft_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)
      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/shft_cmd_ctrl.sv
// Replays buffered shift requests as spaced start pulses
// with operands held stable from setup through gap.
module shft_cmd_ctrl
  import shft_cmd_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AMT_W     = AMT_W_DEF,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  output logic             start,
  output logic             shft,
  output logic [AMT_W-1:0] n,
  output logic             busy,
  output logic [7:0]       issued_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int CMAX = (PULSE_LEN > GAP_LEN) ?
                        PULSE_LEN : GAP_LEN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = 1 + AMT_W;
  localparam int OW   = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             shft_q, shft_d;
  logic [AMT_W-1:0] n_q, n_d;
  logic [7:0]       issued_q, issued_d;
  logic [7:0]       drop_q, drop_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OW-1:0]    fifo_count;
  logic             head_dir;
  logic [AMT_W-1:0] head_amt;
  logic             head_zero;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign head_dir  = fifo_rdata[AMT_W];
  assign head_amt  = fifo_rdata[AMT_W-1:0];
  assign head_zero = (head_amt == '0);

  shft_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cmd_dir, cmd_amt}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head_zero) state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_PULSE;
        cnt_d   = CW'(PULSE_LEN - 1);
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CW'(GAP_LEN - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so start is glitch-free.
  always_comb begin
    start_d  = (state_d == ST_PULSE);
    shft_d   = shft_q;
    n_d      = n_q;
    issued_d = issued_q;
    drop_d   = drop_q;
    if (fifo_pop && !head_zero) begin
      shft_d = head_dir;
      n_d    = head_amt;
    end
    if (fifo_pop && head_zero)
      drop_d = drop_q + 8'd1;
    if (state_q == ST_SETUP)
      issued_d = issued_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      shft_q   <= 1'b0;
      n_q      <= '0;
      issued_q <= '0;
      drop_q   <= '0;
    end else begin
      start_q  <= start_d;
      shft_q   <= shft_d;
      n_q      <= n_d;
      issued_q <= issued_d;
      drop_q   <= drop_d;
    end
  end

  assign start      = start_q;
  assign shft       = shft_q;
  assign n          = n_q;
  assign issued_cnt = issued_q;
  assign drop_cnt   = drop_q;
  assign busy       = (state_q != ST_IDLE) ||
                      (fifo_count != '0);

endmodule
